// File: rtl/trap_value_csr.sv
// Machine trap-value CSR (mtval): captures the highest-priority exception value on a trap,
// supports CSRRW/CSRRS/CSRRC software access and tracks trap-handler nesting depth.
module trap_value_csr #(
    parameter int          XLEN     = 32,
    parameter int          NUM_SRC  = 4,
    parameter int          NEST_W   = 2,
    parameter logic [11:0] CSR_ADDR = 12'h343,
    localparam int         SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    set_cause_in,
    input  logic [NUM_SRC-1:0]      src_valid_in,
    input  logic [NUM_SRC*XLEN-1:0] src_tval_in,
    input  logic                    mret_in,
    input  logic                    wr_en_in,
    input  logic [1:0]              csr_op_in,
    input  logic [11:0]             csr_addr_in,
    input  logic [XLEN-1:0]         data_wr_in,
    output logic [XLEN-1:0]         mtval_out,
    output logic [SRC_W-1:0]        src_id_out,
    output logic                    in_handler_out,
    output logic [NEST_W-1:0]       nest_cnt_out,
    output logic                    overflow_out,
    output logic                    capture_pulse_out
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] HANDLER = 1'b1;

    localparam logic [NEST_W-1:0] NEST_MAX = {NEST_W{1'b1}};

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [0:0]      state;
    logic            sel_hit;
    logic [SRC_W-1:0] sel_id;
    logic [XLEN-1:0] sel_tval;
    logic            csr_hit;

    // Scan from the highest index down so the lowest valid index is the last (winning) assignment.
    always_comb begin
        sel_hit  = 1'b0;
        sel_id   = '0;
        sel_tval = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid_in[i]) begin
                sel_hit  = 1'b1;
                sel_id   = SRC_W'(i);
                sel_tval = src_tval_in[i*XLEN +: XLEN];
            end
        end
    end

    assign csr_hit = wr_en_in && (csr_addr_in == CSR_ADDR);

    // A trap capture always takes precedence over a software write in the same cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mtval_out  <= '0;
            src_id_out <= '0;
        end else if (set_cause_in) begin
            mtval_out <= sel_hit ? sel_tval : '0;
            if (sel_hit) begin
                src_id_out <= sel_id;
            end
        end else if (csr_hit) begin
            case (csr_op_in)
                OP_WRITE: mtval_out <= data_wr_in;
                OP_SET:   mtval_out <= mtval_out | data_wr_in;
                OP_CLEAR: mtval_out <= mtval_out & ~data_wr_in;
                default:  mtval_out <= mtval_out;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= IDLE;
            nest_cnt_out      <= '0;
            overflow_out      <= 1'b0;
            capture_pulse_out <= 1'b0;
        end else begin
            capture_pulse_out <= set_cause_in;
            case (state)
                IDLE: begin
                    if (set_cause_in) begin
                        state        <= HANDLER;
                        nest_cnt_out <= '0;
                    end
                end
                HANDLER: begin
                    if (set_cause_in) begin
                        // Saturate rather than wrap so depth is never under-reported.
                        if (nest_cnt_out == NEST_MAX) begin
                            overflow_out <= 1'b1;
                        end else begin
                            nest_cnt_out <= nest_cnt_out + 1'b1;
                        end
                    end else if (mret_in) begin
                        if (nest_cnt_out == '0) begin
                            state <= IDLE;
                        end else begin
                            nest_cnt_out <= nest_cnt_out - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_handler_out = (state == HANDLER);

endmodule
